// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART transmitter:
//   state_e        transmitter FSM states
//   PAR_*          cfg_parity encodings (2'b11 behaves as PAR_NONE)
//   tick_cnt_w()   width of the oversampling tick counter, sized so the same
//                  counter can time a double-length (two stop bit) period
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Counter must reach 2*OS-1 for a two-stop-bit period.
   function automatic int tick_cnt_w(input int os);
      return (os < 2) ? 2 : $clog2(2 * os);
   endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg_if
// Producer-side handshake of the transmitter.
//   din         data word (only the low cfg_dbits bits are sent)
//   din_valid   producer has a word on din
//   din_ready   input FIFO not full
//   fifo_count  current FIFO occupancy
// master = byte producer, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_cfg_if #(
   parameter int DBIT_MAX   = 8,
   parameter int FIFO_DEPTH = 4
);
   logic [DBIT_MAX-1:0]          din;
   logic                         din_valid;
   logic                         din_ready;
   logic [$clog2(FIFO_DEPTH):0]  fifo_count;

   modport master (output din, output din_valid, input din_ready, input fifo_count);
   modport slave  (input din, input din_valid, output din_ready, output fifo_count);
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO feeding the transmitter.
//   clk, reset   clock, asynchronous active-low reset
//   push/wr_data write request and data (ignored while full)
//   pop/rd_data  read request (ignored while empty); rd_data shows the head
//   full, empty  occupancy flags
//   count        occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and count define which entries
   // are valid, and leaving the array unreset lets it map to plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
// UART transmitter with runtime frame format and input FIFO.
//   clk, reset      system clock, asynchronous active-low reset
//   s_tick          oversampling pulse, OS per bit period
//   cfg_dbits       data bits (5..DBIT_MAX, anything else means DBIT_MAX)
//   cfg_parity      00 none, 01 even, 10 odd, 11 none
//   cfg_stop2       two stop bits when set
//   din_if          producer handshake (din/din_valid/din_ready/fifo_count)
//   tx              registered serial output, idles high
//   tx_busy         frame in progress
//   tx_done_tick    one-cycle pulse after the last tick of the final stop bit
// Format is captured at pop time; config changes mid-frame are ignored.
// -----------------------------------------------------------------------------
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DBIT_MAX   = 8,
   parameter int OS         = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               s_tick,
   input  logic [3:0]         cfg_dbits,
   input  logic [1:0]         cfg_parity,
   input  logic               cfg_stop2,
   uart_tx_cfg_if.slave       din_if,
   output logic               tx,
   output logic               tx_busy,
   output logic               tx_done_tick
);
   localparam int TW = tick_cnt_w(OS);
   localparam logic [TW-1:0] TICK_LAST  = TW'(OS - 1);
   localparam logic [TW-1:0] TICK_LAST2 = TW'(2 * OS - 1);

   logic                fifo_full, fifo_empty, pop;
   logic [DBIT_MAX-1:0] fifo_rd_data;

   uart_tx_fifo #(.WIDTH(DBIT_MAX), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (din_if.din_valid && !fifo_full),
      .wr_data (din_if.din),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (din_if.fifo_count)
   );

   assign din_if.din_ready = !fifo_full;

   state_e              state_q, state_d;
   logic [TW-1:0]       tick_q, tick_d;
   logic [3:0]          bit_q, bit_d;
   logic [DBIT_MAX-1:0] shift_q, shift_d;
   logic [3:0]          dbits_q, dbits_d;
   logic                par_en_q, par_en_d;
   logic                par_bit_q, par_bit_d;
   logic                stop2_q, stop2_d;
   logic                tx_q, tx_d;
   logic                done_q, done_d;
   logic                load;
   logic [3:0]          dbits_eff;
   logic                pop_par;

   assign dbits_eff = (cfg_dbits < 4'd5 || cfg_dbits > 4'(DBIT_MAX)) ? 4'(DBIT_MAX) : cfg_dbits;

   // Parity over the bits that will actually be sent; upper din bits are ignored.
   always_comb begin
      pop_par = 1'b0;
      for (int i = 0; i < DBIT_MAX; i++) begin
         if (i < int'(dbits_eff)) pop_par = pop_par ^ fifo_rd_data[i];
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      dbits_d   = dbits_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      stop2_d   = stop2_q;
      done_d    = 1'b0;
      load      = 1'b0;

      case (state_q)
         IDLE: if (!fifo_empty) load = 1'b1;
         START: if (s_tick) begin
            if (tick_q == TICK_LAST) begin
               state_d = DATA;
               tick_d  = '0;
               bit_d   = '0;
            end else tick_d = tick_q + TW'(1);
         end
         DATA: if (s_tick) begin
            if (tick_q == TICK_LAST) begin
               tick_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == dbits_q - 4'd1) state_d = par_en_q ? PARITY : STOP;
               else bit_d = bit_q + 4'd1;
            end else tick_d = tick_q + TW'(1);
         end
         PARITY: if (s_tick) begin
            if (tick_q == TICK_LAST) begin
               state_d = STOP;
               tick_d  = '0;
            end else tick_d = tick_q + TW'(1);
         end
         STOP: if (s_tick) begin
            if (tick_q == (stop2_q ? TICK_LAST2 : TICK_LAST)) begin
               done_d = 1'b1;
               // Chain straight into the next start bit when more data waits.
               if (!fifo_empty) load = 1'b1;
               else state_d = IDLE;
            end else tick_d = tick_q + TW'(1);
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         state_d   = START;
         tick_d    = '0;
         shift_d   = fifo_rd_data;
         dbits_d   = dbits_eff;
         par_en_d  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
         par_bit_d = pop_par ^ (cfg_parity == PAR_ODD);
         stop2_d   = cfg_stop2;
      end
   end

   assign pop = load;

   // tx is loaded from the next-state view so the pin is a clean flop output.
   always_comb begin
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_bit_d;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         dbits_q   <= 4'(DBIT_MAX);
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         dbits_q   <= dbits_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         stop2_q   <= stop2_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
      end
   end

   assign tx           = tx_q;
   assign tx_busy      = (state_q != IDLE);
   assign tx_done_tick = done_q;

endmodule
